reed_debouncer: RTL and testbench

- Upstream conditioning stage for the reed-switch LED state machine.
- Takes the raw, bouncy, asynchronous reed contact and passes it through a synchronizer, then a debounce FSM.
- Drives a clean level into the downstream sensor input. Also provides one-cycle edge pulses and a wrapping actuation counter.

---
 rtl/reed_debouncer.sv | 172 +++++++++++++++++
 tb/tb_reed_debouncer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/reed_debouncer.sv
// reed_debouncer: conditions a raw, bouncy reed contact into a clean level.
// The contact is synchronized, then a debounce FSM accepts a new level only
// after DEBOUNCE_CYCLES consecutive agreeing samples. Also provides one-cycle
// rise/fall pulses and a wrapping count of accepted rising transitions.
// Optional macro REED_GLITCH_COUNT_EN adds a saturating count of rejected
// bounces on glitch_count; without it glitch_count is tied to zero.
module reed_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16,
    parameter int EVENT_W         = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sensor_raw,
    input  logic               clear_count,
    output logic               sensor_clean,
    output logic               rise_pulse,
    output logic               fall_pulse,
    output logic [EVENT_W-1:0] event_count,
    output logic [EVENT_W-1:0] glitch_count
);

    localparam logic [1:0] STABLE_LOW  = 2'd0;
    localparam logic [1:0] PEND_HIGH   = 2'd1;
    localparam logic [1:0] STABLE_HIGH = 2'd2;
    localparam logic [1:0] PEND_LOW    = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_synced;
    logic [1:0]             r_state;
    logic [1:0]             w_stateNext;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cntNext;
    logic                   w_acceptRise;
    logic                   w_acceptFall;
    logic                   r_sensorClean;
    logic                   r_risePulse;
    logic                   r_fallPulse;
    logic [EVENT_W-1:0]     r_eventCount;

    // Shift the asynchronous contact through the synchronizer chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sensor_raw};
        end
    end

    assign w_synced = r_sync[SYNC_STAGES-1];

    // Next-state logic: a pending level must survive every counting sample,
    // including the last one, or the FSM falls back to the old stable level.
    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt;
        w_acceptRise = 1'b0;
        w_acceptFall = 1'b0;
        case (r_state)
            STABLE_LOW: begin
                if (w_synced) begin
                    w_stateNext = PEND_HIGH;
                    w_cntNext   = '0;
                end
            end
            PEND_HIGH: begin
                if (!w_synced) begin
                    w_stateNext = STABLE_LOW;
                end else if (r_cnt == CNT_LAST) begin
                    w_stateNext  = STABLE_HIGH;
                    w_cntNext    = '0;
                    w_acceptRise = 1'b1;
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            STABLE_HIGH: begin
                if (!w_synced) begin
                    w_stateNext = PEND_LOW;
                    w_cntNext   = '0;
                end
            end
            PEND_LOW: begin
                if (w_synced) begin
                    w_stateNext = STABLE_HIGH;
                end else if (r_cnt == CNT_LAST) begin
                    w_stateNext  = STABLE_LOW;
                    w_cntNext    = '0;
                    w_acceptFall = 1'b1;
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_stateNext = STABLE_LOW;
                w_cntNext   = '0;
            end
        endcase
    end

    // FSM state and debounce counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // Clean level and pulses are registered together so each pulse lines up
    // with the first cycle that shows the new level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sensorClean <= 1'b0;
            r_risePulse   <= 1'b0;
            r_fallPulse   <= 1'b0;
        end else begin
            r_risePulse <= w_acceptRise;
            r_fallPulse <= w_acceptFall;
            if (w_acceptRise) begin
                r_sensorClean <= 1'b1;
            end else if (w_acceptFall) begin
                r_sensorClean <= 1'b0;
            end
        end
    end

    // Count accepted rises, wrapping silently; clear has priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_eventCount <= '0;
        end else if (clear_count) begin
            r_eventCount <= '0;
        end else if (w_acceptRise) begin
            r_eventCount <= r_eventCount + EVENT_W'(1);
        end
    end

`ifdef REED_GLITCH_COUNT_EN
    logic               w_abort;
    logic [EVENT_W-1:0] r_glitchCount;

    assign w_abort = ((r_state == PEND_HIGH) && !w_synced) ||
                     ((r_state == PEND_LOW)  &&  w_synced);

    // Count rejected bounces, sticking at all-ones; clear has priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_glitchCount <= '0;
        end else if (clear_count) begin
            r_glitchCount <= '0;
        end else if (w_abort && (r_glitchCount != '1)) begin
            r_glitchCount <= r_glitchCount + EVENT_W'(1);
        end
    end

    assign glitch_count = r_glitchCount;
`else
    assign glitch_count = '0;
`endif

    assign sensor_clean = r_sensorClean;
    assign rise_pulse   = r_risePulse;
    assign fall_pulse   = r_fallPulse;
    assign event_count  = r_eventCount;

endmodule

// File: tb/tb_reed_debouncer.sv
// tb_reed_debouncer: table-driven bench for reed_debouncer with
// SYNC_STAGES=2, DEBOUNCE_CYCLES=4 and EVENT_W=2 so event_count wraps quickly.
// Expected outputs per cycle are built from the documented latency
// (SYNC_STAGES+DEBOUNCE_CYCLES+1 edges) and queued when each vector is driven.
module tb_reed_debouncer;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int EW   = 2;
    localparam int LAT  = SYNC + DEB + 1;
    localparam int SEG  = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          sensorRaw;
    logic          clearCount;
    logic          sensorClean;
    logic          risePulse;
    logic          fallPulse;
    logic [EW-1:0] eventCount;
    logic [EW-1:0] glitchCount;

    typedef struct {
        logic          raw;
        logic          clr;
        logic          clean;
        logic          rise;
        logic          fall;
        logic [EW-1:0] ev;
        logic [EW-1:0] gl;
    } vec_t;

    vec_t vecs[$];
    vec_t expQ[$];
    int   total  = 0;
    int   bad    = 0;
    int   vecIdx = 0;
    logic expClean;
    int   expEv;
    int   expGl;

    reed_debouncer #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (16),
        .EVENT_W        (EW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sensor_raw  (sensorRaw),
        .clear_count (clearCount),
        .sensor_clean(sensorClean),
        .rise_pulse  (risePulse),
        .fall_pulse  (fallPulse),
        .event_count (eventCount),
        .glitch_count(glitchCount)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s vec=%0d got=%0h want=%0h", name, vecIdx, act, exp);
        end
    endtask

    task automatic addVec(input logic raw, input logic clr, input logic rise, input logic fall);
        vec_t v;
        v.raw   = raw;
        v.clr   = clr;
        v.clean = expClean;
        v.rise  = rise;
        v.fall  = fall;
        v.ev    = EW'(expEv);
        v.gl    = EW'(expGl);
        vecs.push_back(v);
    endtask

    task automatic glitchBump();
`ifdef REED_GLITCH_COUNT_EN
        if (expGl < (1 << EW) - 1) expGl++;
`endif
    endtask

    task automatic addIdle(input int n);
        for (int i = 0; i < n; i++) addVec(expClean, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic addTransition(input logic clrAtAccept);
        logic newLevel;
        newLevel = !expClean;
        for (int e = 1; e <= SEG; e++) begin
            if (e == LAT) begin
                expClean = newLevel;
                if (newLevel) expEv = (expEv + 1) % (1 << EW);
                if (clrAtAccept) begin
                    expEv = 0;
                    expGl = 0;
                end
            end
            addVec(newLevel, (e == LAT) && clrAtAccept, (e == LAT) && newLevel, (e == LAT) && !newLevel);
        end
    endtask

    // Raw leaves the stable level for h edges; the FSM aborts at edge h+SYNC+1.
    task automatic addGlitch(input int h);
        logic oldLevel;
        oldLevel = expClean;
        for (int e = 1; e <= SEG; e++) begin
            if (e == h + SYNC + 1) glitchBump();
            addVec((e <= h) ? !oldLevel : oldLevel, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic checkOutput();
        vec_t v;
        if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard vec=%0d got=empty want=entry", vecIdx);
        end else begin
            v = expQ.pop_front();
            checkVal("sensor_clean", 8'(sensorClean), 8'(v.clean));
            checkVal("rise_pulse",   8'(risePulse),   8'(v.rise));
            checkVal("fall_pulse",   8'(fallPulse),   8'(v.fall));
            checkVal("event_count",  8'(eventCount),  8'(v.ev));
            checkVal("glitch_count", 8'(glitchCount), 8'(v.gl));
        end
        vecIdx++;
    endtask

    // Drive one vector right after a falling edge, then check after the rise.
    task automatic applyStimulus(input vec_t v);
        sensorRaw  = v.raw;
        clearCount = v.clr;
        expQ.push_back(v);
        @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_clean"}, 8'(sensorClean), 8'd0);
        checkVal({tag, "_rise"},  8'(risePulse),   8'd0);
        checkVal({tag, "_fall"},  8'(fallPulse),   8'd0);
        checkVal({tag, "_event"}, 8'(eventCount),  8'd0);
        checkVal({tag, "_glitch"}, 8'(glitchCount), 8'd0);
    endtask

    // Main sequence: reset, table phase, then mid-debounce reset.
    initial begin
        reset      = 1'b1;
        sensorRaw  = 1'b0;
        clearCount = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        reset = 1'b0;

        expClean = 1'b0;
        expEv    = 0;
        expGl    = 0;

        addIdle(20);
        addTransition(1'b0);
        addIdle(3);
        addTransition(1'b0);
        addGlitch(3);
        addGlitch(DEB);
        addTransition(1'b0);
        addGlitch(2);
        addGlitch(1);
        addGlitch(DEB);
        addTransition(1'b0);
        addTransition(1'b0);
        addTransition(1'b0);
        addTransition(1'b0);
        addTransition(1'b0);
        addTransition(1'b0);
        addTransition(1'b0);
        addTransition(1'b0);
        addTransition(1'b1);
        addTransition(1'b0);
        addTransition(1'b0);
        addTransition(1'b0);

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);
        $display("[TB] table phase complete, %0d vectors", vecs.size());

        // Enter PEND_HIGH and count to 2, then reset asynchronously.
        vecs.delete();
        for (int e = 1; e <= SYNC + 3; e++) addVec(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);
        #1;
        reset = 1'b1;
        #1;
        checkAllZero("midReset");
        #1;
        reset = 1'b0;

        // Raw still high: the full latency must restart from scratch.
        vecs.delete();
        expClean = 1'b0;
        expEv    = 0;
        expGl    = 0;
        addTransition(1'b0);
        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain got=%0d want=0", expQ.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
